// File: rtl/imem_responder.sv
// Fetch-port read responder. A one-word last-fetch buffer sits in front of an
// 8-bit asynchronous SRAM, and each 16-bit miss is filled as two wait-stated byte reads.
module imem_responder #(
  parameter int WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_re,
  input  logic [23:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_ready,
  input  logic        inval,
  output logic [24:0] ext_addr,
  output logic        ext_ce_n,
  output logic        ext_oe_n,
  input  logic [7:0]  ext_data
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;
  localparam logic [2:0] WaitLast = 3'(WAIT);

  state_e      state_q;
  logic [23:0] tag_q;
  logic        valid_q;
  logic [15:0] data_q;
  logic [7:0]  lo_q;
  logic [2:0]  wcnt_q;
  logic        inval_seen_q;
  logic [24:0] ext_addr_q;
  logic        ext_sel_n_q;

  logic tag_match;
  logic hit;
  logic phase_end;

  assign tag_match = (mem_addr == tag_q);
  assign hit       = valid_q && mem_re && tag_match;
  assign phase_end = (wcnt_q == WaitLast);

  // DONE ignores valid so that a fill overlapped by inval still returns its word.
  always_comb begin
    mem_ready = 1'b0;
    if (state_q == IDLE)      mem_ready = hit;
    else if (state_q == DONE) mem_ready = mem_re && tag_match;
  end

  assign mem_data = data_q;
  assign ext_addr = ext_addr_q;
  assign ext_ce_n = ext_sel_n_q;
  assign ext_oe_n = ext_sel_n_q;

  // The fill address lives in ext_addr_q[24:1]; bit 0 selects the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      lo_q         <= '0;
      wcnt_q       <= '0;
      inval_seen_q <= 1'b0;
      ext_addr_q   <= '0;
      ext_sel_n_q  <= 1'b1;
    end else begin
      if (inval) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_re && !hit) begin
            ext_addr_q  <= {mem_addr, 1'b0};
            ext_sel_n_q <= 1'b0;
            wcnt_q      <= '0;
            state_q     <= LO;
          end
        end
        LO: begin
          if (inval) inval_seen_q <= 1'b1;
          if (phase_end) begin
            lo_q       <= ext_data;
            ext_addr_q <= {ext_addr_q[24:1], 1'b1};
            wcnt_q     <= '0;
            state_q    <= HI;
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        HI: begin
          if (inval) inval_seen_q <= 1'b1;
          if (phase_end) begin
            data_q      <= {ext_data, lo_q};
            tag_q       <= ext_addr_q[24:1];
            valid_q     <= !(inval_seen_q || inval);
            ext_sel_n_q <= 1'b1;
            wcnt_q      <= '0;
            state_q     <= DONE;
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        DONE: begin
          inval_seen_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (WAIT=0 and WAIT=1) against a
// byte-addressed SRAM model that returns garbage until the access time has elapsed.
module tb_imem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        re   [2];
  logic [23:0] addr [2];
  logic        inv  [2];
  logic        rdy  [2];
  logic [15:0] dat  [2];
  logic [24:0] xa   [2];
  logic        ce   [2];
  logic        oe   [2];
  logic [7:0]  xd   [2];

  int checks = 0;
  int failures = 0;

  logic        mv [2];
  logic [23:0] mt [2];

  logic [24:0] tr_addr [64];
  logic        tr_ce   [64];
  logic        tr_oe   [64];

  imem_responder #(.WAIT(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .mem_re(re[0]), .mem_addr(addr[0]), .mem_data(dat[0]),
    .mem_ready(rdy[0]), .inval(inv[0]), .ext_addr(xa[0]), .ext_ce_n(ce[0]),
    .ext_oe_n(oe[0]), .ext_data(xd[0])
  );
  imem_responder #(.WAIT(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .mem_re(re[1]), .mem_addr(addr[1]), .mem_data(dat[1]),
    .mem_ready(rdy[1]), .inval(inv[1]), .ext_addr(xa[1]), .ext_ce_n(ce[1]),
    .ext_oe_n(oe[1]), .ext_data(xd[1])
  );

  function automatic logic [7:0] sram_byte(input logic [24:0] a);
    case (a)
      25'h0000200: return 8'h34;
      25'h0000201: return 8'h12;
      25'h1FFFFFE: return 8'hAA;
      25'h1FFFFFF: return 8'h55;
      default:     return a[7:0] ^ a[15:8] ^ {a[23:17], a[24]} ^ 8'hC3;
    endcase
  endfunction

  function automatic logic [15:0] word_of(input logic [23:0] a);
    return {sram_byte({a, 1'b1}), sram_byte({a, 1'b0})};
  endfunction

  // Instance g has WAIT=g: data is only good once the address has been held g cycles.
  logic [24:0] pa [2];
  int          pg [2];
  int          age [2];
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      age[g] = (xa[g] != pa[g]) ? 0 : pg[g] + 1;
      xd[g]  = (!ce[g] && !oe[g] && age[g] >= g) ? sram_byte(xa[g]) : ~sram_byte(xa[g]);
    end
  end
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pa[g] <= xa[g];
      pg[g] <= age[g];
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++)
      if (rdy[g] === 1'b1 && re[g] !== 1'b1) begin
        failures++;
        $display("FAIL ready_without_re dut=%0d ready=%0b mem_re=%0b", g, rdy[g], re[g]);
      end
  end

  // Starts just after a rising edge; returns just after the capture edge (or timeout).
  task automatic req(input int d, input logic [23:0] a, input int max_c, input int inval_c,
                     input int drop_c, output int lat, output logic [15:0] rd,
                     output logic inv_done);
    logic got;
    got = 1'b0; lat = -1; rd = '0; inv_done = 1'b0;
    re[d] = 1'b1;
    addr[d] = a;
    for (int c = 0; c < max_c; c++) begin
      inv[d] = (c == inval_c);
      if (c == inval_c) inv_done = 1'b1;
      if (c == drop_c) re[d] = 1'b0;
      @(negedge clk);
      tr_addr[c] = xa[d];
      tr_ce[c]   = ce[d];
      tr_oe[c]   = oe[d];
      if (rdy[d] === 1'b1) begin
        got = 1'b1; lat = c; rd = dat[d];
        break;
      end
      @(posedge clk); #1;
    end
    if (got) begin
      @(posedge clk); #1;
    end
    re[d] = 1'b0;
    inv[d] = 1'b0;
  endtask

  task automatic pulse_inval(input int d);
    inv[d] = 1'b1;
    @(posedge clk); #1;
    inv[d] = 1'b0;
    mv[d] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      re[g] = 1'b1; addr[g] = '0; inv[g] = 1'b0; mv[g] = 1'b0; mt[g] = '0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++; if (rdy[g] !== 1'b0) begin failures++; $display("FAIL reset_ready dut=%0d got=%0b exp=0", g, rdy[g]); end
      checks++; if (dat[g] !== 16'h0) begin failures++; $display("FAIL reset_data dut=%0d got=%0h exp=0", g, dat[g]); end
      checks++; if (xa[g] !== 25'h0) begin failures++; $display("FAIL reset_ext_addr dut=%0d got=%0h exp=0", g, xa[g]); end
      checks++; if (ce[g] !== 1'b1 || oe[g] !== 1'b1) begin failures++; $display("FAIL reset_ce_oe dut=%0d got=%0b%0b exp=11", g, ce[g], oe[g]); end
    end
    @(posedge clk); #1;
    re[0] = 1'b0; re[1] = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_miss_basic;
    int lat; logic [15:0] rd; logic iv;
    req(1, 24'h000100, 20, -1, -1, lat, rd, iv);
    checks++; if (lat !== 5) begin failures++; $display("FAIL miss_latency got=%0d exp=5", lat); end
    checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL miss_data got=%0h exp=1234", rd); end
    checks++; if (tr_ce[0] !== 1'b1) begin failures++; $display("FAIL idle_ce got=%0b exp=1", tr_ce[0]); end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (tr_addr[c] !== ((c <= 2) ? 25'h200 : 25'h201) || tr_ce[c] !== 1'b0 || tr_oe[c] !== 1'b0) begin
        failures++;
        $display("FAIL miss_ext_cycle%0d got addr=%0h ce=%0b oe=%0b exp addr=%0h ce=0 oe=0",
                 c, tr_addr[c], tr_ce[c], tr_oe[c], (c <= 2) ? 25'h200 : 25'h201);
      end
    end
    checks++; if (tr_ce[5] !== 1'b1 || tr_oe[5] !== 1'b1) begin failures++; $display("FAIL done_deselect got=%0b%0b exp=11", tr_ce[5], tr_oe[5]); end
    mv[1] = 1'b1; mt[1] = 24'h000100;
  endtask

  task automatic test_hit;
    int lat; logic [15:0] rd; logic iv;
    req(1, 24'h000100, 20, -1, -1, lat, rd, iv);
    checks++; if (lat !== 0) begin failures++; $display("FAIL hit_latency got=%0d exp=0", lat); end
    checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL hit_data got=%0h exp=1234", rd); end
    checks++; if (tr_ce[0] !== 1'b1) begin failures++; $display("FAIL hit_ce got=%0b exp=1", tr_ce[0]); end
    pulse_inval(1);
    req(1, 24'h000100, 20, -1, -1, lat, rd, iv);
    checks++; if (lat !== 5) begin failures++; $display("FAIL after_inval_latency got=%0d exp=5", lat); end
    checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL after_inval_data got=%0h exp=1234", rd); end
    mv[1] = 1'b1; mt[1] = 24'h000100;
  endtask

  task automatic test_inval_fill;
    int lat; logic [15:0] rd; logic iv; int k;
    for (int d = 0; d < 2; d++) begin
      k = $urandom_range(1, 2 * d + 3);
      req(d, 24'h000010, 20, k, -1, lat, rd, iv);
      checks++; if (lat !== 2 * d + 3) begin failures++; $display("FAIL inval_fill_latency dut=%0d k=%0d got=%0d exp=%0d", d, k, lat, 2 * d + 3); end
      checks++; if (rd !== word_of(24'h10)) begin failures++; $display("FAIL inval_fill_data dut=%0d got=%0h exp=%0h", d, rd, word_of(24'h10)); end
      req(d, 24'h000010, 20, -1, -1, lat, rd, iv);
      checks++; if (lat !== 2 * d + 3) begin failures++; $display("FAIL inval_refetch_latency dut=%0d got=%0d exp=%0d", d, lat, 2 * d + 3); end
      checks++; if (rd !== word_of(24'h10)) begin failures++; $display("FAIL inval_refetch_data dut=%0d got=%0h exp=%0h", d, rd, word_of(24'h10)); end
      mv[d] = 1'b1; mt[d] = 24'h000010;
    end
  endtask

  task automatic test_drop;
    int lat; logic [15:0] rd; logic iv;
    req(1, 24'h000040, 8, -1, 2, lat, rd, iv);
    checks++; if (lat !== -1) begin failures++; $display("FAIL drop_ready got_cycle=%0d exp=none", lat); end
    checks++; if (tr_ce[5] !== 1'b1) begin failures++; $display("FAIL drop_fill_done got_ce=%0b exp=1", tr_ce[5]); end
    req(1, 24'h000040, 20, -1, -1, lat, rd, iv);
    checks++; if (lat !== 0) begin failures++; $display("FAIL drop_then_hit_latency got=%0d exp=0", lat); end
    checks++; if (rd !== word_of(24'h40)) begin failures++; $display("FAIL drop_then_hit_data got=%0h exp=%0h", rd, word_of(24'h40)); end
    mv[1] = 1'b1; mt[1] = 24'h000040;
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] rd; logic iv;
    re[1] = 1'b1; addr[1] = 24'h000077;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ce[1] !== 1'b0) begin failures++; $display("FAIL pre_reset_ce got=%0b exp=0", ce[1]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (xa[1] !== 25'h0) begin failures++; $display("FAIL async_reset_addr got=%0h exp=0", xa[1]); end
    checks++; if (ce[1] !== 1'b1 || oe[1] !== 1'b1) begin failures++; $display("FAIL async_reset_ce_oe got=%0b%0b exp=11", ce[1], oe[1]); end
    checks++; if (dat[1] !== 16'h0 || rdy[1] !== 1'b0) begin failures++; $display("FAIL async_reset_data got=%0h/%0b exp=0/0", dat[1], rdy[1]); end
    re[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mv[0] = 1'b0; mv[1] = 1'b0;
    req(1, 24'h000077, 20, -1, -1, lat, rd, iv);
    checks++; if (lat !== 5) begin failures++; $display("FAIL post_reset_latency got=%0d exp=5", lat); end
    checks++; if (rd !== word_of(24'h77)) begin failures++; $display("FAIL post_reset_data got=%0h exp=%0h", rd, word_of(24'h77)); end
    mv[1] = 1'b1; mt[1] = 24'h000077;
  endtask

  task automatic test_wait0_top;
    int lat; logic [15:0] rd; logic iv;
    req(0, 24'hFFFFFF, 20, -1, -1, lat, rd, iv);
    checks++; if (lat !== 3) begin failures++; $display("FAIL w0_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 16'h55AA) begin failures++; $display("FAIL w0_data got=%0h exp=55aa", rd); end
    checks++; if (tr_addr[1] !== 25'h1FFFFFE || tr_ce[1] !== 1'b0) begin failures++; $display("FAIL w0_lo_addr got=%0h ce=%0b exp=1fffffe ce=0", tr_addr[1], tr_ce[1]); end
    checks++; if (tr_addr[2] !== 25'h1FFFFFF || tr_ce[2] !== 1'b0) begin failures++; $display("FAIL w0_hi_addr got=%0h ce=%0b exp=1ffffff ce=0", tr_addr[2], tr_ce[2]); end
    mv[0] = 1'b1; mt[0] = 24'hFFFFFF;
    req(0, 24'hFFFFFF, 20, -1, -1, lat, rd, iv);
    checks++; if (lat !== 0 || rd !== 16'h55AA) begin failures++; $display("FAIL w0_hit got=%0d/%0h exp=0/55aa", lat, rd); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] rd; logic iv;
    logic [23:0] seq [4];
    int exp_lat [4];
    seq = '{24'h003000, 24'h003001, 24'h003001, 24'h003000};
    exp_lat = '{5, 5, 0, 5};
    for (int i = 0; i < 4; i++) begin
      req(1, seq[i], 20, -1, -1, lat, rd, iv);
      checks++;
      if (lat !== exp_lat[i] || rd !== word_of(seq[i])) begin
        failures++;
        $display("FAIL b2b_%0d got=%0d/%0h exp=%0d/%0h", i, lat, rd, exp_lat[i], word_of(seq[i]));
      end
    end
    mv[1] = 1'b1; mt[1] = 24'h003000;
  endtask

  task automatic test_random;
    int lat; logic [15:0] rd; logic iv; int ic;
    logic [23:0] pool [4];
    logic [23:0] a;
    logic exp_hit;
    int exp_lat;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) pool[i] = 24'($urandom);
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if ($urandom_range(0, 4) == 0) pulse_inval(d);
        a = pool[$urandom_range(0, 3)];
        ic = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * d + 3)) : -1;
        exp_hit = mv[d] && (mt[d] == a);
        exp_lat = exp_hit ? 0 : 2 * d + 3;
        req(d, a, 20, ic, -1, lat, rd, iv);
        checks++;
        if (lat !== exp_lat || rd !== word_of(a)) begin
          failures++;
          $display("FAIL random dut=%0d n=%0d addr=%0h got=%0d/%0h exp=%0d/%0h",
                   d, n, a, lat, rd, exp_lat, word_of(a));
        end
        if (!exp_hit) begin mv[d] = 1'b1; mt[d] = a; end
        if (iv) mv[d] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_miss_basic();
    test_hit();
    test_inval_fill();
    test_drop();
    test_reset_mid();
    test_wait0_top();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Memory-side responder for the fetch stage's read port. Accepts word-addressed 16-bit read requests (`mem_re`/`mem_addr`), returns `mem_data` with a `mem_ready` qualifier, and fills misses by sequencing two byte reads from an external 8-bit asynchronous SRAM with programmable wait states. A one-entry last-word buffer serves repeated fetches of the same address with zero added latency. Sits between the CPU front end and the board-level program memory.

## Interface

Parameters:
- `WAIT`, default 1: extra cycles each byte address is held before sampling; legal range 0–7.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `mem_re` in 1: read request; the requester holds it and `mem_addr` stable until `mem_ready`.
- `mem_addr` in 24: word address.
- `mem_data` out 16: read data, registered; valid when `mem_ready`=1.
- `mem_ready` out 1: read complete; the requester captures `mem_data` on an edge where `mem_re && mem_ready`.
- `inval` in 1: single-cycle pulse that clears the last-word buffer.
- `ext_addr` out 25: SRAM byte address, registered.
- `ext_ce_n` out 1: SRAM chip enable, active-low, registered.
- `ext_oe_n` out 1: SRAM output enable, active-low, registered.
- `ext_data` in 8: SRAM read data.

## Operation

State is held in these registers: `state`, `tag`[24], `valid`, `data`[16], `lo`[8], and the wait counter `wcnt`[3].

- `mem_data` is always `data`.
- `hit = valid && mem_re && mem_addr == tag`.

State machine:
- IDLE
  - `ext_ce_n`=`ext_oe_n`=1.
  - `mem_ready = hit`, combinational from the inputs.
  - On `mem_re && !hit`: latch `mem_addr` into the fill address. Drive `ext_addr={mem_addr,1'b0}`, `ext_ce_n`=`ext_oe_n`=0, `wcnt=0`. Go to LO.
- LO: holds the byte address for WAIT+1 cycles.
  - When `wcnt==WAIT`: `lo<=ext_data`, `ext_addr<={fill,1'b1}`, `wcnt<=0`, go to HI.
  - Otherwise `wcnt++`.
- HI: holds the byte address for WAIT+1 cycles.
  - When `wcnt==WAIT`: `data<={ext_data,lo}`, `tag<=fill`, set `valid<=!inval_seen`, `ext_ce_n`=`ext_oe_n`<=1, go to DONE.
- DONE: one cycle.
  - `mem_ready = mem_re && mem_addr==tag`, independent of `valid`.
  - Always go to IDLE.

Byte order is little-endian: the low byte is at the even byte address.

Invalidation:
- `inval` in any state clears `valid` on the next edge.
- `inval_seen` is set by `inval` during LO/HI and cleared on entering IDLE.
- A fill overlapped by `inval` still returns its word in DONE, but leaves `valid`=0.

Request withdrawn:
- If `mem_re` drops during LO/HI, the fill completes and updates the buffer normally.
- DONE then asserts no ready.

`mem_addr` changes during a fill are a requester protocol violation. The fill continues with the latched address, and DONE asserts ready only if the current `mem_addr` matches `tag`.

## Timing

Reset values:
- `state`=IDLE, `valid`=0, `data`=0, `tag`=0, `lo`=0, `wcnt`=0, `inval_seen`=0.
- `ext_addr`=0, `ext_ce_n`=1, `ext_oe_n`=1, `mem_ready`=0.

Reset asserted mid-fill aborts immediately. The SRAM is deselected, and no partial word is written to `data` or `valid`.

Latency (request first seen in cycle 0):
- Hit: `mem_ready`=1 in cycle 0, zero wait.
- Miss: LO occupies cycles 1..WAIT+1 and HI occupies WAIT+2..2·WAIT+2, so DONE/`mem_ready` falls in cycle 2·WAIT+3.
  - WAIT=1: ready in cycle 5.
  - WAIT=0: ready in cycle 3.
- Back-to-back: the cycle after DONE is IDLE.
  - A new miss request there starts LO the next cycle.
  - A request for the same word there is a hit.

SRAM sampling:
- `ext_data` is sampled at the final edge of each byte phase, i.e. WAIT+1 cycles after `ext_addr` changed.
- The SRAM access time must fit within WAIT+1 clock periods.

No ready output is ever asserted without `mem_re` high in the same cycle.

Address width: `mem_addr` 24 bits maps to `ext_addr` 25 bits. Address 24'hFFFFFF reads bytes 25'h1FFFFFE and 25'h1FFFFFF, with no wrap.

## Test plan

- Reset, WAIT=1, SRAM[0x000200]=0x34, SRAM[0x000201]=0x12; `mem_re`=1, `mem_addr`=0x000100 → `ext_addr` 0x000200 for 2 cycles then 0x000201 for 2 cycles; `mem_ready`=1 in cycle 5 with `mem_data`=0x1234; `ext_ce_n`=1 from DONE onward.
- Repeat 0x000100 after the fill → `mem_ready`=1 in the same cycle, `mem_data`=0x1234, `ext_ce_n` stays 1. Then pulse `inval`, request again → full miss sequence, ready after 5 cycles.
- `inval` pulsed during HI of a fill of 0x000010 → that request gets ready with correct data in DONE; an immediate re-request of 0x000010 misses (refetch, ready 5 cycles later).
- `mem_re` dropped in cycle 2 of a miss → fill completes, no `mem_ready` in DONE; a later request for the same address hits in 0 cycles.
- `rst_n` low during LO → outputs return to reset values asynchronously; after release, a request to the previously filling address performs a full miss.
- WAIT=0, `mem_addr`=0xFFFFFF, bytes 0xAA/0x55 → `ext_addr` 0x1FFFFFE then 0x1FFFFFF, ready in cycle 3, `mem_data`=0x55AA.
